// File: rtl/axil_reg_bank_pkg.sv
// axil_reg_bank shared types and the address decode helper.
// Optional byte-strobe writes: define AXIL_REG_BANK_WSTRB_EN.
package axil_reg_bank_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] idx;
    } dec_t;

    // off wraps at the bus width, so an address below base lands out of range
    function automatic dec_t addr_decode(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int          nregs,
        input int          addr_w,
        input int          lsb
    );
        logic [63:0] mask;
        logic [63:0] off;
        logic [63:0] span;
        dec_t        d;
        mask = (addr_w >= 64) ? '1 : ((64'd1 << addr_w) - 64'd1);
        off = (addr - base) & mask;
        span = 64'(nregs) << lsb;
        d.hit = (off < span);
        d.idx = 32'(off >> lsb);
        return d;
    endfunction

endpackage

// File: rtl/axil_reg_bank_if.sv
// AXI-Lite bus bundle between an interconnect port and axil_reg_bank.
// The slave modport is the register bank side.
interface axil_reg_bank_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI-Lite register bank with independent write and read FSMs.
// Byte-strobe writes are enabled by defining AXIL_REG_BANK_WSTRB_EN.
module axil_reg_bank
    import axil_reg_bank_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      aclk,
    input  logic                      areset,
    axil_reg_bank_if.slave            s_axil,
    output logic [AXI_DATA_WIDTH-1:0] reg_q [NUM_REGS],
    output logic [NUM_REGS-1:0]       reg_wr_pulse
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W = $clog2(NUM_REGS);

    wr_state_t w_state;
    wr_state_t w_next;
    logic awready_q;
    logic wready_q;
    logic bvalid_q;
    resp_t bresp_q;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0] w_data_q;
    logic aw_hs;
    logic w_hs;
    logic commit;
    logic [AXI_ADDR_WIDTH-1:0] c_addr;
    logic [AXI_DATA_WIDTH-1:0] c_data;
    logic [AXI_DATA_WIDTH-1:0] w_word;
    dec_t w_dec;
    logic [IDX_W-1:0] w_idx;
`ifdef AXIL_REG_BANK_WSTRB_EN
    logic [STRB_W-1:0] w_strb_q;
    logic [STRB_W-1:0] c_strb;
`endif

    rd_state_t r_state;
    rd_state_t r_next;
    logic arready_q;
    logic rvalid_q;
    resp_t rresp_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic ar_hs;
    dec_t r_dec;
    logic [IDX_W-1:0] r_idx;

    assign aw_hs = s_axil.awvalid && awready_q;
    assign w_hs = s_axil.wvalid && wready_q;
    assign ar_hs = s_axil.arvalid && arready_q;

    // Commit picks each half from the bus or from its holding register
    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        c_addr = s_axil.awaddr;
        c_data = s_axil.wdata;
`ifdef AXIL_REG_BANK_WSTRB_EN
        c_strb = s_axil.wstrb;
`endif
        unique case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end else if (aw_hs) begin
                    w_next = W_HAVE_A;
                end else if (w_hs) begin
                    w_next = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                c_addr = aw_addr_q;
                if (w_hs) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end
            end
            W_HAVE_D: begin
                c_data = w_data_q;
`ifdef AXIL_REG_BANK_WSTRB_EN
                c_strb = w_strb_q;
`endif
                if (aw_hs) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axil.bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign w_dec = addr_decode(64'(c_addr), 64'(BASE_ADDR), NUM_REGS,
                               AXI_ADDR_WIDTH, ADDR_LSB);
    assign w_idx = w_dec.idx[IDX_W-1:0];

`ifdef AXIL_REG_BANK_WSTRB_EN
    always_comb begin
        w_word = reg_q[w_idx];
        for (int b = 0; b < STRB_W; b++) begin
            if (c_strb[b]) w_word[8*b +: 8] = c_data[8*b +: 8];
        end
    end
`else
    assign w_word = c_data;
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            awready_q <= 1'b0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q <= OKAY;
            aw_addr_q <= '0;
            w_data_q <= '0;
`ifdef AXIL_REG_BANK_WSTRB_EN
            w_strb_q <= '0;
`endif
            reg_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= RESET_VAL;
        end else begin
            w_state <= w_next;
            awready_q <= (w_next == W_IDLE) || (w_next == W_HAVE_D);
            wready_q <= (w_next == W_IDLE) || (w_next == W_HAVE_A);
            bvalid_q <= (w_next == W_RESP);
            reg_wr_pulse <= '0;
            if (aw_hs) aw_addr_q <= s_axil.awaddr;
            if (w_hs) begin
                w_data_q <= s_axil.wdata;
`ifdef AXIL_REG_BANK_WSTRB_EN
                w_strb_q <= s_axil.wstrb;
`endif
            end
            if (commit) begin
                bresp_q <= w_dec.hit ? OKAY : SLVERR;
                if (w_dec.hit) begin
                    reg_q[w_idx] <= w_word;
                    reg_wr_pulse[w_idx] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (ar_hs) r_next = R_DATA;
            R_DATA: if (s_axil.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign r_dec = addr_decode(64'(s_axil.araddr), 64'(BASE_ADDR), NUM_REGS,
                               AXI_ADDR_WIDTH, ADDR_LSB);
    assign r_idx = r_dec.idx[IDX_W-1:0];

    // Reads sample the register array before any same-edge write lands
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rresp_q <= OKAY;
            rdata_q <= '0;
        end else begin
            r_state <= r_next;
            arready_q <= (r_next == R_IDLE);
            rvalid_q <= (r_next == R_DATA);
            if (ar_hs) begin
                rdata_q <= r_dec.hit ? reg_q[r_idx] : '0;
                rresp_q <= r_dec.hit ? OKAY : SLVERR;
            end
        end
    end

    assign s_axil.awready = awready_q;
    assign s_axil.wready = wready_q;
    assign s_axil.bvalid = bvalid_q;
    assign s_axil.bresp = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid = rvalid_q;
    assign s_axil.rresp = rresp_q;
    assign s_axil.rdata = rdata_q;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Randomized self-checking bench for axil_reg_bank against an array model.
// Strobe expectations follow AXIL_REG_BANK_WSTRB_EN when it is defined.
module tb_axil_reg_bank;

    localparam int NR = 16;
    localparam logic [31:0] RV = 32'hA5A5_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] reg_q [NR];
    logic [NR-1:0] pulse;
    logic [31:0] mdl [NR];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axil_reg_bank_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axil_reg_bank #(
        .NUM_REGS(NR),
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(32),
        .BASE_ADDR(32'h0),
        .RESET_VAL(RV)
    ) dut (
        .aclk(clk),
        .areset(rst),
        .s_axil(bus),
        .reg_q(reg_q),
        .reg_wr_pulse(pulse)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] a);
        return (a - 32'h0) < 32'd64;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'(((a - 32'h0) / 4) % NR);
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) check(tag, reg_q[i], mdl[i]);
    endtask

    task automatic drv_aw(input logic [31:0] a, input int d);
        int n = 0;
        repeat (d) @(negedge clk);
        bus.awaddr = a;
        bus.awvalid = 1'b1;
        while (!bus.awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("aw_timeout", n < 50, 1);
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
    endtask

    task automatic drv_w(input logic [31:0] dat, input logic [3:0] s,
                         input int d);
        int n = 0;
        repeat (d) @(negedge clk);
        bus.wdata = dat;
        bus.wstrb = s;
        bus.wvalid = 1'b1;
        while (!bus.wready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("w_timeout", n < 50, 1);
        @(posedge clk);
        @(negedge clk);
        bus.wvalid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] dat,
                      input logic [3:0] s, input int ad, input int wd,
                      input int bd);
        logic hit;
        int idx;
        int n = 0;
        logic [31:0] nw;
        hit = m_hit(a);
        idx = m_idx(a);
        fork
            drv_aw(a, ad);
            drv_w(dat, s, wd);
        join
        check("wr_pulse", pulse, hit ? (NR'(1) << idx) : '0);
        for (int i = 0; i < bd; i++) begin
            check("b_hold", bus.bvalid, 1);
            check("aw_w_block", {bus.awready, bus.wready}, 0);
            @(negedge clk);
        end
        bus.bready = 1'b1;
        while (!bus.bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_valid", bus.bvalid, 1);
        check("bresp", bus.bresp, hit ? 2'b00 : 2'b10);
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        check("b_drop", bus.bvalid, 0);
        check("pulse_once", pulse, 0);
        if (hit) begin
            nw = mdl[idx];
`ifdef AXIL_REG_BANK_WSTRB_EN
            for (int b = 0; b < 4; b++)
                if (s[b]) nw[8*b +: 8] = dat[8*b +: 8];
`else
            nw = dat;
`endif
            mdl[idx] = nw;
        end
        check_regs("regs_after_wr");
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ed,
                      input logic [1:0] er, input int dly);
        int n = 0;
        bus.araddr = a;
        bus.arvalid = 1'b1;
        while (!bus.arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ar_timeout", n < 50, 1);
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        check("r_latency", bus.rvalid, 1);
        check("rdata", bus.rdata, ed);
        check("rresp", bus.rresp, er);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("r_hold", {bus.rvalid, bus.rdata}, {1'b1, ed});
        end
        bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
        check("r_drop", bus.rvalid, 0);
    endtask

    task automatic rd_m(input logic [31:0] a, input int dly);
        if (m_hit(a)) rd(a, mdl[m_idx(a)], 2'b00, dly);
        else rd(a, 32'h0, 2'b10, dly);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] old3;
        bus.awaddr = '0;
        bus.awvalid = 1'b0;
        bus.wdata = '0;
        bus.wstrb = '0;
        bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0;
        bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        for (int i = 0; i < NR; i++) mdl[i] = RV;

        repeat (3) @(negedge clk);
        check("rst_ready", {bus.awready, bus.wready, bus.arready}, 0);
        check("rst_valid", {bus.bvalid, bus.rvalid}, 0);
        check("rst_pulse", pulse, 0);
        check_regs("rst_regs");
        rst = 1'b0;
        @(negedge clk);
        check("ready_rise", {bus.awready, bus.wready, bus.arready}, 3'b111);

        rd_m(32'h0, 0);
        rd_m(32'h3C, 2);

        wr(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        rd_m(32'h8, 0);

        wr(32'h14, 32'h0BAD_F00D, 4'hF, 3, 0, 4);
        rd_m(32'h14, 1);

        wr(32'h40, 32'h1234_5678, 4'hF, 0, 0, 1);
        rd_m(32'hFFFF_FFFC, 0);

        wr(32'h4, 32'h1122_3344, 4'hF, 0, 0, 0);
        wr(32'h4, 32'hAABB_CCDD, 4'b0101, 1, 0, 0);
`ifdef AXIL_REG_BANK_WSTRB_EN
        check("strobe_reg1", reg_q[1], 32'h11BB_33DD);
`else
        check("strobe_reg1", reg_q[1], 32'hAABB_CCDD);
`endif

        wr(32'hC, 32'h0303_0303, 4'hF, 0, 0, 0);
        old3 = mdl[3];
        fork
            wr(32'hC, 32'hC011_1DE0, 4'hF, 0, 0, 0);
            rd(32'hC, old3, 2'b00, 0);
        join
        rd_m(32'hE, 0);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 7) == 0)
                a = 32'h40 + ($urandom % 32'hFFFF_FFC0);
            else
                a = ($urandom_range(0, NR - 1) << 2) | $urandom_range(0, 3);
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                wr(a, d, 4'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
            else
                rd_m(a, $urandom_range(0, 2));
        end

        bus.awaddr = 32'hC;
        bus.wdata = 32'h5555_AAAA;
        bus.wstrb = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
        check("pre_rst_bvalid", bus.bvalid, 1);
        check("pre_rst_reg3", reg_q[3], 32'h5555_AAAA);
        rst = 1'b1;
        #1;
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_reg3", reg_q[3], RV);
        for (int i = 0; i < NR; i++) mdl[i] = RV;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {bus.awready, bus.wready, bus.bvalid}, 3'b110);
        check_regs("post_rst_regs");
        rd_m(32'hC, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
